// File: rtl/cpu_regfile_pkg.sv
// Shared definitions for the CPU register-file write path: default
// geometry of the register file and the write-arbiter FSM encodings.
package cpu_regfile_pkg;

   localparam int N_REGS_DEF = 8;
   localparam int WIDTH_DEF  = 8;
   localparam int ADDR_W_DEF = 3;

   // IDLE: nothing staged; WRITE: wr_sel pulse active; LOCK: a requester
   // owns the port for its next beat (only reachable with ARB_LOCK_EN).
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      LOCK  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or
// after ptr, wrapping N-1 -> 0. Returns a one-hot grant plus its index.
// Purely combinational so it can be reused by the read-port arbiter.
module rr_arbiter #(
   parameter  int N     = 4,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             en,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx
);

   int   pos;
   logic found;

   // Scan N positions starting at ptr; the first requester seen wins.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int k = 0; k < N; k++) begin
         pos = int'(ptr) + k;
         if (pos >= N) pos = pos - N;
         if (en && !found && req[IDX_W'(pos)]) begin
            gnt[IDX_W'(pos)] = 1'b1;
            idx              = IDX_W'(pos);
            found            = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the CPU register file. N_REQ requesters compete
// round-robin for the single write port via valid/ready; the winner is
// registered and drives a one-hot wr_sel pulse plus shared wr_data one
// cycle after the handshake. Out-of-range addresses complete the handshake
// but raise addr_err instead of a wr_sel pulse.
// Optional feature macro: ARB_LOCK_EN (requester may hold the port across
// consecutive beats with req_lock).
module regfile_write_arbiter
   import cpu_regfile_pkg::*;
#(
   parameter  int N_REQ  = 4,
   parameter  int N_REGS = N_REGS_DEF,
   parameter  int WIDTH  = WIDTH_DEF,
   parameter  int ADDR_W = ADDR_W_DEF,
   localparam int SRC_W  = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*WIDTH-1:0]  req_data,
   input  logic [N_REQ-1:0]        req_lock,
   output logic [N_REQ-1:0]        req_ready,
   input  logic                    freeze,
   output logic [N_REGS-1:0]       wr_sel,
   output logic [WIDTH-1:0]        wr_data,
   output logic [SRC_W-1:0]        wr_src,
   output logic                    addr_err
);

   arb_state_e        state, state_nxt;
   logic [SRC_W-1:0]  rr_ptr, rr_ptr_nxt, arb_ptr, win_idx;
   logic [N_REQ-1:0]  arb_req, gnt;
   logic              arb_en, handshake, addr_bad;
   logic [ADDR_W-1:0] win_addr;
   logic [WIDTH-1:0]  win_data;
   logic [N_REGS-1:0] sel_nxt;

   function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] i);
      return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
   endfunction

   // Grants are suppressed during reset and pipeline stalls.
   assign arb_en = rst_n & ~freeze;

`ifdef ARB_LOCK_EN
   logic [SRC_W-1:0] lock_idx;
   logic             lock_hold;

   // While locked and the owner is still valid, only the owner may win;
   // if the owner dropped valid, normal arbitration resumes after it.
   always_comb begin
      arb_req   = req_valid;
      arb_ptr   = rr_ptr;
      lock_hold = (state == LOCK) && req_valid[lock_idx];
      if (state == LOCK) begin
         if (lock_hold) begin
            arb_req           = '0;
            arb_req[lock_idx] = req_valid[lock_idx];
            arb_ptr           = lock_idx;
         end else begin
            arb_ptr = wrap_inc(lock_idx);
         end
      end
   end

   // Remember which requester owns the lock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              lock_idx <= '0;
      else if (handshake && req_lock[win_idx]) lock_idx <= win_idx;
   end
`else
   logic unused_lock;
   assign unused_lock = ^req_lock;
   assign arb_req     = req_valid;
   assign arb_ptr     = rr_ptr;
`endif

   rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
      .req (arb_req),
      .ptr (arb_ptr),
      .en  (arb_en),
      .gnt (gnt),
      .idx (win_idx)
   );

   assign req_ready = gnt;
   assign handshake = |(gnt & req_valid);
   assign win_addr  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
   assign win_data  = req_data[int'(win_idx)*WIDTH +: WIDTH];
   assign addr_bad  = int'(win_addr) >= N_REGS;

   // Decode the winning address into the one-hot register select.
   always_comb begin
      sel_nxt = '0;
      for (int r = 0; r < N_REGS; r++) begin
         sel_nxt[r] = handshake && (win_addr == ADDR_W'(r));
      end
   end

   // Next state and round-robin pointer update.
   always_comb begin
      state_nxt  = IDLE;
      rr_ptr_nxt = rr_ptr;
      if (handshake) begin
         state_nxt  = WRITE;
         rr_ptr_nxt = wrap_inc(win_idx);
`ifdef ARB_LOCK_EN
         if (req_lock[win_idx]) begin
            state_nxt  = LOCK;
            rr_ptr_nxt = rr_ptr;
         end
`endif
      end
`ifdef ARB_LOCK_EN
      else if (state == LOCK) begin
         if (req_valid[lock_idx]) state_nxt  = LOCK;
         else                     rr_ptr_nxt = wrap_inc(lock_idx);
      end
`endif
   end

   // State register and registered write stage; a reset discards any
   // staged write. wr_data and wr_src hold between accepted beats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         wr_sel   <= '0;
         wr_data  <= '0;
         wr_src   <= '0;
         addr_err <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state    <= state_nxt;
         rr_ptr   <= rr_ptr_nxt;
         wr_sel   <= sel_nxt;
         addr_err <= handshake && addr_bad;
         if (handshake) begin
            wr_data <= win_data;
            wr_src  <= win_idx;
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter (N_REQ=4, N_REGS=6, so
// addresses 6 and 7 are out of range). Expected writes are pushed to a
// scoreboard when a grant is predicted and popped one clock later.
module tb_regfile_write_arbiter;

   localparam int NR = 4;
   localparam int NG = 6;
   localparam int AW = 3;
   localparam int DW = 8;

   typedef struct {
      logic [NG-1:0] sel;
      logic [DW-1:0] data;
      logic [1:0]    src;
      logic          err;
   } wr_exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NR-1:0]    req_valid;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_lock;
   logic [NR-1:0]    req_ready;
   logic             freeze;
   logic [NG-1:0]    wr_sel;
   logic [DW-1:0]    wr_data;
   logic [1:0]       wr_src;
   logic             addr_err;

   int tests_run    = 0;
   int tests_failed = 0;

   wr_exp_t sb[$];
   int      obs_log[$];
   int      m_ptr;
   bit      m_lock;
   int      m_lock_idx;
   logic [DW-1:0] last_data;
   logic [1:0]    last_src;

   regfile_write_arbiter #(.N_REQ(NR), .N_REGS(NG), .WIDTH(DW), .ADDR_W(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_lock  (req_lock),
      .req_ready (req_ready),
      .freeze    (freeze),
      .wr_sel    (wr_sel),
      .wr_data   (wr_data),
      .wr_src    (wr_src),
      .addr_err  (addr_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic l);
      req_valid[i]         = v;
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
      req_lock[i]          = l;
   endtask

   function automatic logic [NR-1:0] model_gnt();
      int p;
      p = m_ptr;
      if (!rst_n || freeze) return '0;
`ifdef ARB_LOCK_EN
      if (m_lock) begin
         if (req_valid[m_lock_idx]) return NR'(1) << m_lock_idx;
         p = (m_lock_idx + 1) % NR;
      end
`endif
      for (int k = 0; k < NR; k++) begin
         if (req_valid[(p + k) % NR]) return NR'(1) << ((p + k) % NR);
      end
      return '0;
   endfunction

   function automatic void model_update(input int g);
      if (g >= 0) begin
`ifdef ARB_LOCK_EN
         if (req_lock[g]) begin
            m_lock = 1'b1; m_lock_idx = g;
            return;
         end
         m_lock = 1'b0;
`endif
         m_ptr = (g + 1) % NR;
      end
`ifdef ARB_LOCK_EN
      else if (m_lock && !req_valid[m_lock_idx]) begin
         m_lock = 1'b0;
         m_ptr  = (m_lock_idx + 1) % NR;
      end
`endif
   endfunction

   function automatic int idx_of(input logic [NR-1:0] v);
      for (int k = 0; k < NR; k++) if (v[k] === 1'b1) return k;
      return -1;
   endfunction

   // One clock: check the grant, push the expected write, then compare the
   // registered outputs after the edge. Entered and left at posedge+1.
   task automatic step(input string tag);
      logic [NR-1:0] eg;
      logic [AW-1:0] a;
      wr_exp_t       e, o;
      int            g;
      #1;
      eg = model_gnt();
      tests_run++;
      if (req_ready !== eg) begin
         tests_failed++;
         $display("FAIL %s req_ready: got %b want %b", tag, req_ready, eg);
      end
      obs_log.push_back(idx_of(req_ready));
      g = idx_of(eg);
      if (g >= 0) begin
         a      = req_addr[g*AW +: AW];
         e.sel  = (int'(a) < NG) ? (NG'(1) << a) : '0;
         e.err  = (int'(a) >= NG);
         e.data = req_data[g*DW +: DW];
         e.src  = 2'(g);
         sb.push_back(e);
         last_data = e.data;
         last_src  = e.src;
      end
      model_update(g);
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         o = sb.pop_front();
         tests_run++;
         if (wr_sel !== o.sel || wr_data !== o.data || wr_src !== o.src || addr_err !== o.err) begin
            tests_failed++;
            $display("FAIL %s write: got sel=%b data=%h src=%0d err=%b want sel=%b data=%h src=%0d err=%b",
                     tag, wr_sel, wr_data, wr_src, addr_err, o.sel, o.data, o.src, o.err);
         end
      end else begin
         tests_run++;
         if (wr_sel !== '0 || addr_err !== 1'b0 || wr_data !== last_data || wr_src !== last_src) begin
            tests_failed++;
            $display("FAIL %s idle: got sel=%b err=%b data=%h src=%0d want sel=0 err=0 data=%h src=%0d",
                     tag, wr_sel, addr_err, wr_data, wr_src, last_data, last_src);
         end
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; req_valid = '0; req_lock = '0; freeze = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_ptr = 0; m_lock = 1'b0; m_lock_idx = 0;
      last_data = '0; last_src = '0;
      sb.delete(); obs_log.delete();
   endtask

   task automatic check_grant(input string tag, input int pos, input int want);
      tests_run++;
      if (obs_log.size() <= pos || obs_log[pos] != want) begin
         tests_failed++;
         $display("FAIL %s grant[%0d]: got %0d want %0d", tag, pos,
                  (obs_log.size() > pos) ? obs_log[pos] : -99, want);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; freeze = 1'b0; req_lock = '0;
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(i), DW'(8'h10 + i), 1'b0);
      #1;
      tests_run++;
      if (req_ready !== '0 || wr_sel !== '0 || addr_err !== 1'b0 || wr_data !== '0 || wr_src !== '0) begin
         tests_failed++;
         $display("FAIL reset_state: got rdy=%b sel=%b err=%b data=%h src=%0d want all zero",
                  req_ready, wr_sel, addr_err, wr_data, wr_src);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (req_ready !== '0 || wr_sel !== '0) begin
         tests_failed++;
         $display("FAIL reset_hold: got rdy=%b sel=%b want 0 0", req_ready, wr_sel);
      end
      rst_n = 1'b1;
      m_ptr = 0; m_lock = 1'b0; m_lock_idx = 0;
      last_data = '0; last_src = '0;
      obs_log.delete();
      step("reset_first");
      check_grant("reset_first", 0, 0);
      // Stage a write, then reset asynchronously while it is pulsing.
      req_valid = '0;
      set_req(2, 1'b1, 3'd3, 8'h3C, 1'b0);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (wr_sel !== '0 || req_ready !== '0 || wr_data !== '0) begin
         tests_failed++;
         $display("FAIL reset_mid: got sel=%b rdy=%b data=%h want 0 0 00", wr_sel, req_ready, wr_data);
      end
      apply_reset();
      step("reset_after");
   endtask

   task automatic test_single();
      apply_reset();
      set_req(2, 1'b1, 3'd5, 8'hA5, 1'b0);
      step("single");
      req_valid = '0;
      step("single_once");
   endtask

   task automatic test_round_robin();
      apply_reset();
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(i + 1), DW'(8'h40 + 3 * i), 1'b0);
      for (int c = 0; c < 6; c++) step("rr");
      for (int c = 0; c < 6; c++) check_grant("rr_order", c, c % NR);
      req_valid = '0;
      step("rr_tail");
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 5; c++) begin
         req_valid = '0;
         set_req(c % NR, 1'b1, AW'($urandom_range(0, 7)), DW'($urandom), 1'b0);
         set_req((c + 2) % NR, 1'b1, AW'($urandom_range(0, 5)), DW'($urandom), 1'b0);
         step("b2b");
      end
      req_valid = '0;
      step("b2b_tail");
   endtask

   task automatic test_freeze();
      apply_reset();
      set_req(1, 1'b1, 3'd2, 8'h77, 1'b0);
      step("frz_grant1");
      set_req(2, 1'b1, 3'd4, 8'h99, 1'b0);
      freeze = 1'b1;
      step("frz_hold");
      freeze = 1'b0;
      step("frz_release");
      check_grant("frz", 0, 1);
      check_grant("frz", 1, -1);
      check_grant("frz", 2, 2);
      req_valid = '0;
      step("frz_tail");
   endtask

   task automatic test_bad_addr();
      apply_reset();
      set_req(0, 1'b1, 3'd7, 8'hEE, 1'b0);
      step("bad7");
      set_req(1, 1'b1, 3'd6, 8'h66, 1'b0);
      step("bad6_ptr");
      check_grant("bad_ptr", 1, 1);
      req_valid = '0;
      set_req(3, 1'b1, 3'd0, 8'h01, 1'b0);
      step("bad_recover");
      req_valid = '0;
      step("bad_tail");
   endtask

   task automatic test_lock();
      int exp_l[4];
`ifdef ARB_LOCK_EN
      exp_l = '{1, 1, 1, 0};
`else
      exp_l = '{1, 0, 1, 0};
`endif
      apply_reset();
      set_req(0, 1'b1, 3'd1, 8'hB0, 1'b0);
      step("lock_pre");
      set_req(1, 1'b1, 3'd2, 8'hB1, 1'b1);
      step("lock_b1");
      step("lock_b2");
      req_lock[1] = 1'b0;
      step("lock_b3");
      step("lock_b4");
      for (int c = 0; c < 4; c++) check_grant("lock_order", c + 1, exp_l[c]);
      req_valid = '0;
      step("lock_tail");
   endtask

   initial begin
      req_valid = '0; req_addr = '0; req_data = '0; req_lock = '0;
      freeze = 1'b0; rst_n = 1'b0;
      m_ptr = 0; m_lock = 1'b0; m_lock_idx = 0;
      last_data = '0; last_src = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_back_to_back();
      test_freeze();
      test_bad_addr();
      test_lock();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the CPU register file among N requesters (ALU writeback, load unit, move/immediate path, debug port).
- Round-robin arbitration with a valid/ready handshake.
- Registers the winning request and drives a one-hot per-register write select (the `sel` input of each register cell) plus a shared write-data bus.
- Write reaches the register file one cycle after the handshake.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- N_REGS, 8, number of registers in the file
- WIDTH, 8, register data width
- ADDR_W, 3, register address width; N_REGS <= 2**ADDR_W

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester write request
- req_addr  in  N_REQ*ADDR_W  packed target addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- req_data  in  N_REQ*WIDTH  packed write data; requester i at bits [i*WIDTH +: WIDTH]
- req_lock  in  N_REQ  keep grant for next beat (used only with ARB_LOCK_EN)
- req_ready  out  N_REQ  one-hot grant, combinational
- freeze  in  1  pipeline stall: blocks all new grants
- wr_sel  out  N_REGS  one-hot register write select, registered
- wr_data  out  WIDTH  write data to all register cells, registered
- wr_src  out  clog2(N_REQ)  index of requester whose write is on wr_sel
- addr_err  out  1  one-cycle pulse: accepted request addressed a register >= N_REGS

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_sel=0, wr_data=0, wr_src=0, addr_err=0, rr_ptr=0, state=IDLE.
  - req_ready=0 while rst_n is low.
  - Reset mid-transfer discards the staged write; no wr_sel pulse follows.
- Arbitration (combinational):
  - If freeze=0 and any req_valid is set, the winner is the first valid index at or after rr_ptr, searching upward and wrapping N_REQ-1 to 0.
  - req_ready is one-hot on the winner; all zero otherwise.
  - Handshake occurs when req_valid[i] and req_ready[i] are both high.
- Registered stage, on a clk edge after a handshake:
  - wr_sel <= onehot(req_addr[i]); wr_data <= req_data[i]; wr_src <= i.
  - rr_ptr <= (i+1) mod N_REQ.
  - wr_sel is high for exactly one cycle per accepted beat.
  - Back-to-back grants give back-to-back pulses; throughput is 1 write/cycle.
- No handshake in a cycle: next cycle wr_sel=0 and addr_err=0. wr_data and wr_src hold their last value. rr_ptr is unchanged.
- Out-of-range address (req_addr >= N_REGS):
  - Handshake still completes and rr_ptr advances.
  - Next cycle wr_sel=0 and addr_err=1 for one cycle.
- freeze=1:
  - req_ready=0 and rr_ptr is held.
  - A write staged in the previous cycle still pulses; freeze does not cancel it.
- FSM states:
  - IDLE: no write staged.
  - WRITE: wr_sel pulse is active this cycle.
  - LOCK: only with the macro.
- FSM transitions:
  - IDLE -> WRITE on handshake.
  - WRITE -> WRITE on handshake.
  - WRITE -> IDLE otherwise.
- Requester deasserting req_valid without a handshake is legal; nothing is staged.
- Requesters must hold addr/data stable while valid and not ready. The arbiter does not check this.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - A handshake with req_lock[i]=1 enters LOCK. The next grant goes to i exclusively while req_valid[i]=1, and rr_ptr is not advanced.
  - LOCK exits after a handshake with req_lock[i]=0, or when req_valid[i] drops. rr_ptr then advances to i+1.
  - freeze still blocks grants in LOCK.
- Undefined: req_lock is ignored and the LOCK state is not built.

Decomposition:
- Shared package/header cpu_regfile_pkg:
  - N_REGS, WIDTH, ADDR_W defaults
  - FSM state encodings: IDLE=2'd0, WRITE=2'd1, LOCK=2'd2
- One sub-module: rr_arbiter. Inputs: req vector, rr_ptr, enable. Output: one-hot grant plus encoded index. Combinational, reusable for the read-port arbiter.

Test Plan:
- Reset: rst_n=0 with req_valid=4'b1111 -> req_ready=0 and wr_sel=0. After release, first grant goes to requester 0.
- Single request: req 2 valid, addr=5, data=8'hA5 -> req_ready=4'b0100. Next cycle wr_sel=8'b0010_0000, wr_data=8'hA5, wr_src=2, for exactly one cycle.
- Round-robin: all four valid for 6 cycles -> grant order 0,1,2,3,0,1, with one wr_sel pulse each cycle.
- Freeze: freeze=1 one cycle after a grant to 1 -> the staged write still pulses. req_ready=0 during freeze. On release the grant goes to 2.
- Bad address: N_REGS=6, req 0 addr=7 -> handshake completes. Next cycle wr_sel=0 and addr_err=1. rr_ptr=1.
- ARB_LOCK_EN: req 1 holds lock for 3 beats while req 0 is valid -> grants 1,1,1, then 0 after lock drops. Without the macro: grants alternate 1,0,1.
